ahb2_master_arbiter: RTL and testbench
======================================

# ahb2_master_arbiter

Two-master AHB-Lite arbiter that shares one AHB-Lite slave bus between M0 (the Ibex core wrapper's master port) and M1 (a second master, e.g. DMA or debug loader). Each master's address phase is captured into a private pending register, and the master is stalled through its own HREADY. Captured transfers are replayed on the shared bus one at a time: non-pipelined, one address phase then one data phase. The block sits between the masters and the SoC bus decoder/slave mux.

## Interface
- ARB_MODE, 1, 0 = fixed priority (M0 wins), 1 = round-robin
- HCLK  in  1  system clock
- HRESETn  in  1  reset; asynchronous assert, active-low
- M0_HADDR, M1_HADDR  in  32  master address
- M0_HTRANS, M1_HTRANS  in  2  master transfer type; only bit 1 (NONSEQ/SEQ) is significant
- M0_HSIZE, M1_HSIZE  in  3  master size
- M0_HWRITE, M1_HWRITE  in  1  master write
- M0_HWDATA, M1_HWDATA  in  32  master write data (valid in the master's data phase)
- M0_HREADY, M1_HREADY  out  1  per-master ready/stall
- M0_HRDATA, M1_HRDATA  out  32  read data; both driven directly from bus HRDATA
- HADDR  out  32, HTRANS  out  2, HSIZE  out  3, HWRITE  out  1, HWDATA  out  32  shared bus master signals
- HRDATA  in  32, HREADY  in  1  shared bus slave response
- BUS_OWNER  out  1  master owning the current bus transfer (0/1)

## Operation
- Capture, per master x: when Mx_HREADY=1 and Mx_HTRANS[1]=1 at a rising edge, latch HADDR/HSIZE/HWRITE into pend_x and set pend_valid_x. IDLE/BUSY transfers are ignored.
- Mx_HREADY = !pend_valid_x, OR (state==DATA and owner==x and HREADY). A master is therefore stalled from the cycle after capture until its bus data phase completes.
- A new capture in the completing cycle is legal. Set-on-capture takes priority over clear-on-complete for the same master.
- FSM, 3 states, reset = IDLE:
  - IDLE: if any pend_valid, select a winner, set owner, go to ADDR. Otherwise stay in IDLE.
  - ADDR: drive owner's pending address phase (HTRANS=2'b10). Unconditionally go to DATA.
  - DATA: HWDATA = owner's Mx_HWDATA. When HREADY=1, clear pend_valid_owner, update last_grant=owner, and go to IDLE. Otherwise stay in DATA.
- Arbitration, evaluated only in IDLE:
  - ARB_MODE=0: M0 wins whenever pending.
  - ARB_MODE=1: with both pending, the master != last_grant wins. last_grant resets to 1, so M0 wins the first tie.
- Bus outputs outside ADDR: HADDR=0, HTRANS=2'b00, HSIZE=3'b000, HWRITE=0.
- HWDATA=0 outside DATA.
- BUS_OWNER = owner register, reset 0.

## Timing
- Reset values:
  - Mx_HREADY=1, bus outputs 0, BUS_OWNER=0.
  - pend_valid_x=0, state=IDLE, last_grant=1.
- Reset mid-transfer drops all pending transfers with no completion signalled.
- Uncontended latency: master address phase in cycle t, capture at the end of t. Cycle t+1 is IDLE, t+2 is the bus address phase, t+3 is the bus data phase. With HREADY=1, Mx_HREADY=1 in t+3, so the master's data phase is 3 cycles.
- Each bus wait state (HREADY=0 in DATA) adds 1 cycle.
- There is always one IDLE bubble between consecutive bus transfers. Bus throughput is 1 transfer per 3 cycles.
- Both masters capturing in the same cycle: the winner completes as above; the loser's bus address phase follows 3 cycles after the winner's.
- Bus HREADY is ignored outside DATA.

## Test plan
- Single M0 read, addr 0x0000_0010, HREADY=1 → bus NONSEQ at 0x10 in cycle t+2; M0_HREADY low in t+1..t+2, high in t+3; M0_HRDATA equals bus HRDATA in t+3.
- M1 word write, addr 0x2000_0004, data 0xDEADBEEF, 2 wait states → HWRITE=1 in ADDR; HWDATA=0xDEADBEEF held through all 3 DATA cycles; M1_HREADY rises only on the third.
- ARB_MODE=1, both masters issue NONSEQ in the same cycle, repeated 4 times → grant order M0, M1, M0, M1, …; BUS_OWNER toggles. With ARB_MODE=0 → M0 is always served first.
- M0 back-to-back: a new NONSEQ presented in its completing cycle → captured; the next bus address phase comes exactly 3 cycles after the previous one.
- Assert HRESETn low during a DATA wait state → all outputs immediately take their reset values; after release no stale transfer appears on the bus; the first tie goes to M0.
- IDLE and BUSY HTRANS from both masters for 20 cycles → no capture, bus HTRANS=2'b00 throughout, both Mx_HREADY=1.

Source files
------------

// File: rtl/ahb2_master_arbiter.sv
// Two-master AHB-Lite arbiter: captures each master's address phase, replays it non-pipelined on one shared bus.
// Latency 3 cycles capture-to-data (plus bus wait states); masters stall on their own HREADY while a transfer is pending.
module ahb2_master_arbiter (
  input  logic        ARB_MODE,
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic [2:0]  M0_HSIZE,
  input  logic        M0_HWRITE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic [2:0]  M1_HSIZE,
  input  logic        M1_HWRITE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic        BUS_OWNER
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
  } hdr_t;

  state_t     state_q, state_d;
  hdr_t       pend_q [2];
  hdr_t       m_hdr  [2];
  hdr_t       sel_hdr;
  logic [1:0] pend_vld_q;
  logic [1:0] capture;
  logic [1:0] m_hready;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic       winner;
  logic       xfer_done;
  logic       unused_htrans;

  // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  assign unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];

  assign m_hdr[0] = {M0_HADDR, M0_HSIZE, M0_HWRITE};
  assign m_hdr[1] = {M1_HADDR, M1_HSIZE, M1_HWRITE};

  assign xfer_done   = (state_q == ST_DATA) && HREADY;
  assign m_hready[0] = ~pend_vld_q[0] | (xfer_done & ~owner_q);
  assign m_hready[1] = ~pend_vld_q[1] | (xfer_done &  owner_q);
  assign capture     = m_hready & {M1_HTRANS[1], M0_HTRANS[1]};

  // A capture in the completing cycle wins over the clear of the same master.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_vld_q <= 2'b00;
      pend_q[0]  <= '0;
      pend_q[1]  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (capture[i]) begin
          pend_vld_q[i] <= 1'b1;
          pend_q[i]     <= m_hdr[i];
        end else if (xfer_done && (owner_q == i[0])) begin
          pend_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    winner = 1'b0;
    if (pend_vld_q == 2'b11) begin
      winner = ARB_MODE ? ~last_grant_q : 1'b0;
    end else begin
      winner = pend_vld_q[1] & ~pend_vld_q[0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend_vld_q) begin
          owner_d = winner;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        if (HREADY) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel_hdr = pend_q[owner_q];

  always_comb begin
    HADDR  = 32'h0;
    HTRANS = 2'b00;
    HSIZE  = 3'b000;
    HWRITE = 1'b0;
    HWDATA = 32'h0;
    if (state_q == ST_ADDR) begin
      HADDR  = sel_hdr.addr;
      HTRANS = 2'b10;
      HSIZE  = sel_hdr.size;
      HWRITE = sel_hdr.write;
    end
    if (state_q == ST_DATA) begin
      HWDATA = owner_q ? M1_HWDATA : M0_HWDATA;
    end
  end

  assign M0_HREADY = m_hready[0];
  assign M1_HREADY = m_hready[1];
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;
  assign BUS_OWNER = owner_q;

endmodule

// File: tb/tb_ahb2_master_arbiter.sv
// Directed bench for ahb2_master_arbiter: inputs change 1ns after HCLK rise, outputs checked on HCLK fall.
module tb_ahb2_master_arbiter;

  logic        ARB_MODE, HCLK, HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        M0_HWRITE, M1_HWRITE, HREADY;
  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE, BUS_OWNER;
  int          n_assert = 0;
  int          n_fail = 0;

  ahb2_master_arbiter dut (
    .ARB_MODE (ARB_MODE),  .HCLK     (HCLK),      .HRESETn  (HRESETn),
    .M0_HADDR (M0_HADDR),  .M0_HTRANS(M0_HTRANS), .M0_HSIZE (M0_HSIZE),
    .M0_HWRITE(M0_HWRITE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
    .M0_HRDATA(M0_HRDATA),
    .M1_HADDR (M1_HADDR),  .M1_HTRANS(M1_HTRANS), .M1_HSIZE (M1_HSIZE),
    .M1_HWRITE(M1_HWRITE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
    .M1_HRDATA(M1_HRDATA),
    .HADDR    (HADDR),     .HTRANS   (HTRANS),    .HSIZE    (HSIZE),
    .HWRITE   (HWRITE),    .HWDATA   (HWDATA),    .HRDATA   (HRDATA),
    .HREADY   (HREADY),    .BUS_OWNER(BUS_OWNER)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic sample();
    @(negedge HCLK);
  endtask

  task automatic idle_masters();
    M0_HTRANS = 2'b00;
    M1_HTRANS = 2'b00;
  endtask

  task automatic m0_issue(input logic [31:0] a, input logic w);
    M0_HTRANS = 2'b10; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = 3'd2;
  endtask

  task automatic m1_issue(input logic [31:0] a, input logic w);
    M1_HTRANS = 2'b10; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = 3'd2;
  endtask

  initial begin
    ARB_MODE = 1'b0; HRESETn = 1'b1; HREADY = 1'b1; HRDATA = 32'h0;
    M0_HADDR = 32'h0; M0_HTRANS = 2'b00; M0_HSIZE = 3'd0; M0_HWRITE = 1'b0; M0_HWDATA = 32'h0;
    M1_HADDR = 32'h0; M1_HTRANS = 2'b00; M1_HSIZE = 3'd0; M1_HWRITE = 1'b0; M1_HWDATA = 32'h0;

    // reset values
    #2 HRESETn = 1'b0;
    #1;
    chkb("rst_m0_rdy", M0_HREADY, 1'b1);
    chkb("rst_m1_rdy", M1_HREADY, 1'b1);
    chk ("rst_htrans", 32'(HTRANS), 32'd0);
    chk ("rst_haddr",  HADDR, 32'h0);
    chk ("rst_hwdata", HWDATA, 32'h0);
    chkb("rst_owner",  BUS_OWNER, 1'b0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    step();

    // single M0 read at 0x10
    m0_issue(32'h10, 1'b0);
    sample(); chkb("t1_m0_rdy_t0", M0_HREADY, 1'b1); step();
    idle_masters();
    sample(); chkb("t1_m0_rdy_t1", M0_HREADY, 1'b0); chk("t1_htrans_t1", 32'(HTRANS), 32'd0); step();
    sample();
    chk ("t1_htrans_t2", 32'(HTRANS), 32'd2);
    chk ("t1_haddr_t2",  HADDR, 32'h10);
    chkb("t1_hwrite_t2", HWRITE, 1'b0);
    chk ("t1_hsize_t2",  32'(HSIZE), 32'd2);
    chkb("t1_m0_rdy_t2", M0_HREADY, 1'b0);
    chkb("t1_owner_t2",  BUS_OWNER, 1'b0);
    step();
    HRDATA = 32'hCAFE_F00D; HREADY = 1'b1;
    sample();
    chkb("t1_m0_rdy_t3", M0_HREADY, 1'b1);
    chk ("t1_hrdata_t3", M0_HRDATA, 32'hCAFE_F00D);
    chk ("t1_htrans_t3", 32'(HTRANS), 32'd0);
    step();
    sample(); chkb("t1_m0_rdy_t4", M0_HREADY, 1'b1); step();

    // M1 write with two wait states
    m1_issue(32'h2000_0004, 1'b1);
    sample(); step();
    idle_masters(); M1_HWDATA = 32'hDEAD_BEEF;
    sample(); chkb("t2_m1_rdy_t1", M1_HREADY, 1'b0); step();
    sample();
    chk ("t2_htrans_addr", 32'(HTRANS), 32'd2);
    chk ("t2_haddr_addr",  HADDR, 32'h2000_0004);
    chkb("t2_hwrite_addr", HWRITE, 1'b1);
    chkb("t2_owner_addr",  BUS_OWNER, 1'b1);
    chk ("t2_hwdata_addr", HWDATA, 32'h0);
    step();
    for (int k = 0; k < 3; k++) begin
      HREADY = (k == 2);
      sample();
      chk ("t2_hwdata_data", HWDATA, 32'hDEAD_BEEF);
      chkb("t2_m1_rdy_data", M1_HREADY, k == 2);
      step();
    end
    HREADY = 1'b1; M1_HWDATA = 32'h0;
    sample();
    chk ("t2_htrans_after", 32'(HTRANS), 32'd0);
    chk ("t2_hwdata_after", HWDATA, 32'h0);
    chkb("t2_m1_rdy_after", M1_HREADY, 1'b1);
    step();

    // round-robin, simultaneous requests, four rounds
    ARB_MODE = 1'b1;
    for (int r = 0; r < 4; r++) begin
      m0_issue(32'h1000 + 32'(r) * 32'd16, 1'b0);
      m1_issue(32'h2000 + 32'(r) * 32'd16, 1'b0);
      sample(); step();
      idle_masters();
      sample(); chkb("t3_m0_rdy_wait", M0_HREADY, 1'b0); chkb("t3_m1_rdy_wait", M1_HREADY, 1'b0); step();
      sample(); chkb("t3_owner_first", BUS_OWNER, 1'b0); chk("t3_haddr_first", HADDR, 32'h1000 + 32'(r) * 32'd16); step();
      sample(); chkb("t3_m0_rdy_done", M0_HREADY, 1'b1); chkb("t3_m1_rdy_held", M1_HREADY, 1'b0); step();
      sample(); chk("t3_htrans_bubble", 32'(HTRANS), 32'd0); step();
      sample(); chkb("t3_owner_second", BUS_OWNER, 1'b1); chk("t3_haddr_second", HADDR, 32'h2000 + 32'(r) * 32'd16); step();
      sample(); chkb("t3_m1_rdy_done", M1_HREADY, 1'b1); step();
    end

    // M0 re-issues in its completing cycle while M1 waits: fixed vs round-robin
    for (int m = 0; m < 2; m++) begin
      ARB_MODE = (m == 1);
      m0_issue(32'h100, 1'b0); m1_issue(32'h200, 1'b0);
      sample(); step();
      idle_masters();
      sample(); step();
      sample(); chkb("t4_owner_a", BUS_OWNER, 1'b0); chk("t4_haddr_a", HADDR, 32'h100); step();
      m0_issue(32'h104, 1'b0);
      sample(); chkb("t4_m0_rdy_complete", M0_HREADY, 1'b1); step();
      idle_masters();
      sample(); chkb("t4_m0_rdy_recapt", M0_HREADY, 1'b0); chk("t4_htrans_bubble", 32'(HTRANS), 32'd0); step();
      sample();
      chkb("t4_owner_b", BUS_OWNER, m == 1);
      chk ("t4_haddr_b", HADDR, (m == 1) ? 32'h200 : 32'h104);
      chk ("t4_htrans_b", 32'(HTRANS), 32'd2);
      step();
      sample(); step();
      sample(); step();
      sample();
      chkb("t4_owner_c", BUS_OWNER, m == 0);
      chk ("t4_haddr_c", HADDR, (m == 1) ? 32'h104 : 32'h200);
      step();
      sample(); chkb("t4_rdy_c", (m == 1) ? M0_HREADY : M1_HREADY, 1'b1); step();
      sample(); chk("t4_htrans_end", 32'(HTRANS), 32'd0); step();
    end

    // reset during a DATA wait state
    m1_issue(32'h300, 1'b1);
    sample(); step();
    M1_HTRANS = 2'b00; M1_HWDATA = 32'h1234_5678; m0_issue(32'h400, 1'b0);
    sample(); chkb("t5_m0_capture", M0_HREADY, 1'b1); step();
    M0_HTRANS = 2'b00;
    sample(); chkb("t5_owner_addr", BUS_OWNER, 1'b1); chk("t5_haddr", HADDR, 32'h300); chkb("t5_m0_rdy_pend", M0_HREADY, 1'b0); step();
    HREADY = 1'b0;
    sample(); chk("t5_hwdata_wait", HWDATA, 32'h1234_5678); chkb("t5_m1_rdy_wait", M1_HREADY, 1'b0);
    #1 HRESETn = 1'b0;
    #1;
    chkb("t5_rst_m0_rdy", M0_HREADY, 1'b1);
    chkb("t5_rst_m1_rdy", M1_HREADY, 1'b1);
    chkb("t5_rst_owner",  BUS_OWNER, 1'b0);
    chk ("t5_rst_htrans", 32'(HTRANS), 32'd0);
    chk ("t5_rst_haddr",  HADDR, 32'h0);
    chk ("t5_rst_hwdata", HWDATA, 32'h0);
    chkb("t5_rst_hwrite", HWRITE, 1'b0);
    chk ("t5_rst_hsize",  32'(HSIZE), 32'd0);
    step();
    HREADY = 1'b1; M1_HWDATA = 32'h0;
    step();
    HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample(); chk("t5_no_stale", 32'(HTRANS), 32'd0); chkb("t5_m0_rdy_post", M0_HREADY, 1'b1); step();
    end
    m0_issue(32'h500, 1'b0); m1_issue(32'h600, 1'b0);
    sample(); step();
    idle_masters();
    sample(); step();
    sample(); chkb("t5_tie_owner", BUS_OWNER, 1'b0); chk("t5_tie_haddr", HADDR, 32'h500); step();
    sample(); step();
    sample(); step();
    sample(); chkb("t5_tie_owner2", BUS_OWNER, 1'b1); chk("t5_tie_haddr2", HADDR, 32'h600); step();
    sample(); step();

    // IDLE/BUSY only: nothing may be captured
    for (int i = 0; i < 20; i++) begin
      M0_HTRANS = (i % 2 == 0) ? 2'b00 : 2'b01;
      M1_HTRANS = (i % 2 == 0) ? 2'b01 : 2'b00;
      M0_HADDR  = $urandom;
      M1_HADDR  = $urandom;
      sample();
      chk ("t6_htrans", 32'(HTRANS), 32'd0);
      chkb("t6_m0_rdy", M0_HREADY, 1'b1);
      chkb("t6_m1_rdy", M1_HREADY, 1'b1);
      step();
    end
    idle_masters();
    for (int k = 0; k < 2; k++) begin
      sample(); chk("t6_htrans_tail", 32'(HTRANS), 32'd0); step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
